// File: rtl/time_set_scan.sv
// MM:SS clock with a RUN/SET_MIN/SET_SEC editor and a 4-digit multiplexed display.
// Time is kept as packed BCD; digit/anode/digSet are registered off the current scan index.
module time_set_scan #(
  parameter int TICK_DIV  = 50000000,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnMode,
  input  logic       btnInc,
  input  logic       En,
  output logic [3:0] digit,
  output logic       digEn,
  output logic       digSet,
  output logic [3:0] anode,
  output logic [1:0] mode
);

  localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {RUN = 2'b00, SET_MIN = 2'b01, SET_SEC = 2'b10} mode_e;

  mode_e         state, state_nxt;
  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] scan_cnt;
  logic [BW-1:0] blink_cnt;
  logic [1:0]    idx;
  logic          blink_phase;
  logic [7:0]    min_bcd, sec_bcd;
  logic          tick, edit_inc, editing;

  // BCD 00..59 increment with wrap to 00
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign tick     = (state == RUN) && (tick_cnt == TICK_MAX);
  assign edit_inc = btnInc && !btnMode;
  assign mode     = state;

  always_comb begin
    state_nxt = state;
    if (btnMode) begin
      case (state)
        RUN:     state_nxt = SET_MIN;
        SET_MIN: state_nxt = SET_SEC;
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Timebase and time fields; tick only fires in RUN, edits only outside RUN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      min_bcd  <= 8'h00;
      sec_bcd  <= 8'h00;
    end else begin
      if (state != RUN) tick_cnt <= '0;
      else if (tick)    tick_cnt <= '0;
      else              tick_cnt <= tick_cnt + 1'b1;

      if (tick) begin
        sec_bcd <= bcd_inc(sec_bcd);
        if (sec_bcd == 8'h59) min_bcd <= bcd_inc(min_bcd);
      end else if (edit_inc && state == SET_MIN) begin
        min_bcd <= bcd_inc(min_bcd);
      end else if (edit_inc && state == SET_SEC) begin
        sec_bcd <= bcd_inc(sec_bcd);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt    <= '0;
      idx         <= 2'd0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      if (scan_cnt == SCAN_MAX) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      if (blink_cnt == BLINK_MAX) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign editing = ((state == SET_MIN) && idx[1]) || ((state == SET_SEC) && !idx[1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit  <= 4'd0;
      anode  <= 4'b1110;
      digSet <= 1'b1;
      digEn  <= 1'b0;
    end else begin
      case (idx)
        2'd0:    digit <= sec_bcd[3:0];
        2'd1:    digit <= sec_bcd[7:4];
        2'd2:    digit <= min_bcd[3:0];
        default: digit <= min_bcd[7:4];
      endcase
      anode  <= En ? ~(4'b0001 << idx) : 4'b1111;
      digSet <= ~(editing && !blink_phase);
      digEn  <= En;
    end
  end

endmodule

// File: tb/tb_time_set_scan.sv
// Directed + randomized bench for time_set_scan with a seconds/cycle-count reference model.
module tb_time_set_scan;

  localparam int TD = 4, SD = 2, BD = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, btnMode = 1'b0, btnInc = 1'b0, En = 1'b0;
  logic [3:0] digit, anode;
  logic       digEn, digSet;
  logic [1:0] mode;

  time_set_scan #(.TICK_DIV(TD), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .btnMode(btnMode), .btnInc(btnInc), .En(En),
    .digit(digit), .digEn(digEn), .digSet(digSet), .anode(anode), .mode(mode)
  );

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0;

  // Reference model: time as plain minute/second integers, display position
  // derived from the number of cycles since reset, tick from cycles spent in RUN.
  int m_min = 0, m_sec = 0, m_mode = 0, m_cyc = 0, m_run = 0;
  logic [3:0] e_digit, e_anode;
  logic       e_digset, e_digen;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic bm, input logic bi, input logic e);
    int pos, blink, t;
    bit edit;
    rst_n = r; btnMode = bm; btnInc = bi; En = e;
    if (!r) begin
      m_min = 0; m_sec = 0; m_mode = 0; m_cyc = 0; m_run = 0;
      e_digit = 4'd0; e_anode = 4'b1110; e_digset = 1'b1; e_digen = 1'b0;
    end else begin
      pos   = (m_cyc / SD) % 4;
      blink = 1 - ((m_cyc / BD) % 2);
      case (pos)
        0: e_digit = 4'(m_sec % 10);
        1: e_digit = 4'(m_sec / 10);
        2: e_digit = 4'(m_min % 10);
        default: e_digit = 4'(m_min / 10);
      endcase
      edit     = (m_mode == 1 && pos >= 2) || (m_mode == 2 && pos < 2);
      e_digset = !(edit && blink == 0);
      e_anode  = e ? ~(4'(1) << pos) : 4'b1111;
      e_digen  = e;
      if (m_mode == 0) begin
        if (m_run % TD == TD - 1) begin
          t = (m_min * 60 + m_sec + 1) % 3600;
          m_min = t / 60; m_sec = t % 60;
        end
        m_run++;
      end else begin
        m_run = 0;
      end
      if (bm) m_mode = (m_mode + 1) % 3;
      else if (bi && m_mode == 1) m_min = (m_min + 1) % 60;
      else if (bi && m_mode == 2) m_sec = (m_sec + 1) % 60;
      m_cyc++;
    end
    @(posedge clk); #1;
    chk("mode",   {2'b00, mode},   4'(m_mode));
    chk("digit",  digit,           e_digit);
    chk("anode",  anode,           e_anode);
    chk("digSet", {3'b000, digSet}, {3'b000, e_digset});
    chk("digEn",  {3'b000, digEn},  {3'b000, e_digen});
    btnMode = 1'b0; btnInc = 1'b0;
  endtask

  initial begin
    // Reset values
    step(0, 0, 0, 0);
    step(0, 1, 1, 1);

    // Free run from 00:00 for 60 ticks -> 01:00
    repeat (240) step(1, 0, 0, 1);
    repeat (8) step(1, 0, 0, 1);

    // Preload 59:59, return to RUN, one tick rolls to 00:00
    step(1, 1, 0, 1);
    while (m_min != 59) step(1, 0, 1, 1);
    step(1, 1, 0, 1);
    while (m_sec != 59) step(1, 0, 1, 1);
    step(1, 1, 0, 1);
    repeat (TD + 8) step(1, 0, 0, 1);

    // SET_MIN with 61 increments: min advances by 1 mod 60, no ticks
    step(1, 1, 0, 1);
    repeat (61) step(1, 0, 1, 1);
    repeat (10) step(1, 0, 0, 1);
    step(1, 1, 0, 1);
    step(1, 1, 0, 1);

    // btnMode wins over btnInc from RUN
    step(1, 1, 1, 1);
    chk("mode_prio", {2'b00, mode}, 4'b0001);
    step(1, 1, 0, 1);
    step(1, 1, 0, 1);

    // Blink masking while editing seconds
    step(1, 1, 0, 1);
    step(1, 1, 0, 1);
    repeat (24) step(1, 0, 0, 1);
    step(1, 1, 0, 1);

    // En low blanks anodes next cycle; reset in the middle of SET_MIN
    repeat (3) step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    chk("anode_off", anode, 4'b1111);
    repeat (5) step(1, 0, 0, 0);
    step(1, 1, 0, 1);
    repeat (5) step(1, 0, 1, 1);
    step(0, 0, 1, 1);
    chk("rst_anode", anode, 4'b1110);
    chk("rst_mode", {2'b00, mode}, 4'b0000);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/time_set_scan.md
TIME_SET_SCAN -- requirements
Module: time_set_scan

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 50000000, clk cycles per one-second tick.
REQ-002 SHALL provide parameter SCAN_DIV, default 50000, clk cycles per digit scan slot.
REQ-003 SHALL provide parameter BLINK_DIV, default 12500000, clk cycles per blink half-period.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 btnMode  input  1  single-cycle pulse (debounced upstream), advances edit mode.
REQ-007 btnInc  input  1  single-cycle pulse, increments field being edited.
REQ-008 En  input  1  global display enable.
REQ-009 digit  output  4  BCD value for the currently scanned digit; feeds the 7-segment decoder data input.
REQ-010 digEn  output  1  decoder enable; registered copy of En.
REQ-011 digSet  output  1  decoder blink enable; 0 blanks the current digit.
REQ-012 anode  output  4  active-low one-hot digit select.
REQ-013 mode  output  2  current state: 00 RUN, 01 SET_MIN, 10 SET_SEC.

Function
REQ-014 Time SHALL be held as min (0-59) and sec (0-59), each stored as BCD tens/units; value 60 or above never occurs.
REQ-015 Tick counter SHALL count 0..TICK_DIV-1 in RUN, wrap to 0, and assert a one-cycle tick on the wrap cycle.
REQ-016 In RUN, each tick SHALL increment sec; sec 59->00 SHALL increment min in the same cycle; min 59->00 wraps with no further carry.
REQ-017 FSM SHALL transition RUN->SET_MIN->SET_SEC->RUN, one step per btnMode pulse, taking effect on the next clk edge.
REQ-018 In SET_MIN/SET_SEC the tick counter SHALL be held at 0 and time SHALL not advance from ticks.
REQ-019 In SET_MIN, btnInc SHALL increment min modulo 60; in SET_SEC, it SHALL increment sec modulo 60; no carry between fields; btnInc in RUN is ignored.
REQ-020 btnMode and btnInc asserted in the same cycle: btnMode SHALL win, and btnInc SHALL be ignored.
REQ-021 Entering RUN from SET_SEC SHALL start the tick counter from 0, so the first tick occurs TICK_DIV cycles later.
REQ-022 Scan counter SHALL count 0..SCAN_DIV-1 continuously in all modes; on each wrap, index SHALL advance 0->1->2->3->0.
REQ-023 Index mapping SHALL be: 0 sec units, 1 sec tens, 2 min units, 3 min tens; anode = ~(1<<index).
REQ-024 digit, anode and digSet SHALL be registered and SHALL refer to the same index in the same cycle, with a latency of 1 clk after the index changes.
REQ-025 Blink counter SHALL count 0..BLINK_DIV-1 and toggle blinkPhase on each wrap, in all modes.
REQ-026 digSet SHALL be 0 only when blinkPhase=0 and the scanned digit belongs to the field being edited (indices 2-3 in SET_MIN, 0-1 in SET_SEC); otherwise digSet SHALL be 1.
REQ-027 When En=0, anode SHALL be 4'b1111 on the next cycle; counters and time SHALL keep running.
REQ-028 digEn SHALL equal En delayed by one cycle.

Reset
REQ-029 When rst_n=0 at a clk edge: min=00, sec=00, mode=00, tick/scan/blink counters=0, index=0, blinkPhase=1, digit=0, anode=4'b1110, digSet=1, digEn=0.
REQ-030 Reset SHALL take priority over all inputs, including in the middle of editing or at a tick; no partial update SHALL survive.

Verification (TICK_DIV=4, SCAN_DIV=2, BLINK_DIV=3)
REQ-031 Reset, then En=1 for 240 cycles -> sec reaches 00 with min=01 exactly at the 60th tick; the 59->00 carry occurs in a single cycle.
REQ-032 Preload 59:59 via set mode, return to RUN, wait one tick -> 00:00.
REQ-033 btnMode once, then btnInc x61 -> min=01, sec unchanged, and no ticks counted while in SET_MIN.
REQ-034 btnMode and btnInc in the same cycle from RUN -> mode=01, min unchanged.
REQ-035 In SET_SEC, observe scan -> digSet=0 only for anode 1110/1101 during blinkPhase=0; digSet=1 for 1011/0111.
REQ-036 En=0 mid-scan -> anode=1111 next cycle and digEn=0; assert rst_n=0 during SET_MIN -> all REQ-029 values next cycle.
